// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers responses with their PCs and
// flushes on redirect. Define IFQ_BYPASS_EN to forward responses to decode when the FIFO is empty.
module ifetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_out,
    output logic [XLEN-1:0] inst_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DepthC = (CW+1)'(DEPTH);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] mem_pc_q [DEPTH];
    logic [XLEN-1:0] mem_inst_q [DEPTH];

    logic            grant, rsp, push, pop, bypass;
    logic [CW:0]     credit;
    logic [XLEN-1:0] target_pc;
    logic            unused_redirect_lsb;

    assign target_pc           = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StRun;
        endcase

        // Queued plus in-flight never exceeds DEPTH, so a response always has a free slot.
        credit    = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req  = (state_q == StRun) && !redirect && (credit < DepthC);
        imem_addr = fetch_pc_q;
        grant     = imem_req && imem_gnt;
        rsp       = imem_rvalid && (outstanding_q != '0);

`ifdef IFQ_BYPASS_EN
        bypass = rsp && (discard_q == '0) && (count_q == '0) && !redirect;
`else
        bypass = 1'b0;
`endif

        inst_valid = (count_q != '0) || bypass;
        inst_out   = '0;
        inst_pc    = '0;
        if (count_q != '0) begin
            inst_out = mem_inst_q[rd_ptr_q];
            inst_pc  = mem_pc_q[rd_ptr_q];
        end else if (bypass) begin
            inst_out = imem_rdata;
            inst_pc  = rsp_pc_q;
        end

        pop  = (count_q != '0) && inst_ready;
        push = rsp && (discard_q == '0) && !(bypass && inst_ready);

        fetch_pc_d    = grant ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        rsp_pc_d      = (rsp && discard_q == '0) ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
        discard_d     = (rsp && discard_q != '0) ? discard_q - CW'(1) : discard_q;
        outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
        count_d       = count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);

        // Everything still in flight after this edge belongs to the old stream.
        if (redirect) begin
            fetch_pc_d = target_pc;
            rsp_pc_d   = target_pc;
            discard_d  = outstanding_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StBoot;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_pc_q[i]   <= '0;
                mem_inst_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            if (push && !redirect) begin
                mem_pc_q[wr_ptr_q]   <= rsp_pc_q;
                mem_inst_q[wr_ptr_q] <= imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed phases plus random traffic, checked against a
// queue-based model of fetched, in-flight and deliverable instructions.
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;

    ifetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        live;
    } fly_t;

    fly_t        fly_q[$];   // requests granted but not yet answered, oldest first
    logic [31:0] exp_q[$];   // PCs of instructions decode should see, oldest first
    logic [31:0] pc_m;
    bit          boot;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ pc ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input bit g, input bit rv, input bit rdy, input bit r,
                        input logic [31:0] rpc);
        bit          exp_req, exp_valid, byp, pop, taken;
        logic [31:0] exp_pc;
        fly_t        e;
        imem_gnt    = g;
        inst_ready  = rdy;
        redirect    = r;
        redirect_pc = rpc;
        imem_rvalid = rv;
        imem_rdata  = (fly_q.size() > 0) ? word_of(fly_q[0].pc) : 32'hBAD0_BAD0;
        #1;
        exp_req = !boot && !r && (exp_q.size() + fly_q.size() < DEPTH);
        byp     = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (exp_q.size() == 0) && rv && (fly_q.size() > 0) && fly_q[0].live && !r;
`endif
        exp_valid = (exp_q.size() != 0) || byp;
        exp_pc    = (exp_q.size() != 0) ? exp_q[0] : (byp ? fly_q[0].pc : 32'h0);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, pc_m);
        chk("inst_valid", inst_valid, exp_valid);
        if (exp_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_out", inst_out, word_of(exp_pc));
        end
        // Events of the coming rising edge.
        pop   = exp_valid && rdy;
        taken = 1'b0;
        if (pop) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            else taken = 1'b1;
        end
        if (rv && fly_q.size() > 0) begin
            e = fly_q.pop_front();
            if (e.live && !r && !taken) exp_q.push_back(e.pc);
        end
        if (exp_req && g) begin
            fly_q.push_back('{pc: pc_m, live: 1'b1});
            pc_m = pc_m + 32'd4;
        end
        if (r) begin
            foreach (fly_q[i]) fly_q[i].live = 1'b0;
            exp_q.delete();
            pc_m = {rpc[31:2], 2'b00};
        end
        boot = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        pc_m        = RESET_PC;
        boot        = 1'b1;

        #3;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_out", inst_out, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);

        @(negedge clk);
        reset = 1'b1;

        // Streaming with immediate grant and one-cycle responses.
        repeat (12) step(1, 1, 1, 0, 32'h0);

        // Back-pressure fills the FIFO and stops requests.
        repeat (10) step(1, 1, 0, 0, 32'h0);
        chk("bp_req", imem_req, 1'b0);
        chk("bp_valid", inst_valid, 1'b1);
        repeat (10) step(1, 1, 1, 0, 32'h0);

        // Redirect with exactly two requests outstanding.
        repeat (6) step(0, 1, 1, 0, 32'h0);
        repeat (2) step(1, 0, 1, 0, 32'h0);
        step(0, 0, 1, 1, 32'h0000_0103);
        redirect = 1'b0;
        #1;
        chk("redir_req", imem_req, 1'b1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        chk("redir_valid", inst_valid, 1'b0);
        repeat (10) step(1, 1, 1, 0, 32'h0);

        // Random traffic with redirects landing on grants and responses.
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(3) != 0,
                 $urandom_range(15) == 0, $urandom());
        end

        // Address wrap at the top of the address space.
        repeat (8) step(0, 1, 1, 0, 32'h0);
        step(0, 1, 1, 1, 32'hFFFF_FFF9);
        repeat (12) step(1, 1, 1, 0, 32'h0);

        // Asynchronous reset with three entries queued.
        repeat (6) step(0, 1, 1, 0, 32'h0);
        n = 0;
        while (exp_q.size() != 3 && n < 40) begin
            step(1, 1, 0, 0, 32'h0);
            n++;
        end
        checks++;
        assert (exp_q.size() == 3) else begin
            errors++;
            $error("FAIL fill3: queued %0d expected 3 within 40 cycles", exp_q.size());
        end
        chk("pre_rst_valid", inst_valid, 1'b1);
        #2;
        reset       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        chk("async_req", imem_req, 1'b0);
        chk("async_valid", inst_valid, 1'b0);
        chk("async_out", inst_out, 32'h0);
        chk("async_pc", inst_pc, 32'h0);
        fly_q.delete();
        exp_q.delete();
        pc_m = RESET_PC;
        boot = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) step(1, 1, 1, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
